// File: rtl/segment_scan_ctrl.sv
// Multiplexed 3-digit 7-segment sequencer: 8-bit count -> BCD via serial
// double-dabble, then one-hot digit scan on a shared segment bus.
//
// state | meaning
// IDLE  | waiting for an update request
// CONV  | double-dabble, one bit per cycle, 8 cycles
// LATCH | copy BCD to display digits, pulse done, restart if a request is queued
module segment_scan_ctrl #(
   parameter int SCAN_DIV = 50000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       upd_i,
   input  logic [7:0] count_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] seg_o,
   output logic [2:0] dig_o
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

   logic [1:0]    rst_sync_q, rst_sync_d;
   logic          rst_int;

   state_t        state_q, state_d;
   logic [19:0]   shf_q, shf_d, shf_adj;
   logic [2:0]    iter_q, iter_d;
   logic          pend_q, pend_d;
   logic [7:0]    pend_val_q, pend_val_d;
   logic [11:0]   digits_q, digits_d;
   logic          done_q, done_d;

   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic [7:0]    seg_q, seg_d;
   logic [2:0]    dig_q, dig_d;
   logic [3:0]    nib;
   logic          blank;
   logic          wrap;

   function automatic logic [6:0] dec7(input logic [3:0] v);
      case (v)
         4'd0:    dec7 = 7'h3f;
         4'd1:    dec7 = 7'h06;
         4'd2:    dec7 = 7'h5b;
         4'd3:    dec7 = 7'h4f;
         4'd4:    dec7 = 7'h66;
         4'd5:    dec7 = 7'h6d;
         4'd6:    dec7 = 7'h7d;
         4'd7:    dec7 = 7'h07;
         4'd8:    dec7 = 7'h7f;
         4'd9:    dec7 = 7'h6f;
         default: dec7 = 7'h00;
      endcase
   endfunction

   // Assert immediately, release after two clean clock edges.
   always_comb rst_sync_d = {rst_sync_q[0], 1'b0};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rst_sync_q <= 2'b11;
      else       rst_sync_q <= rst_sync_d;
   end

   assign rst_int = rst_sync_q[1];

   always_comb begin
      state_d    = state_q;
      shf_d      = shf_q;
      iter_d     = iter_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      digits_d   = digits_q;
      done_d     = 1'b0;

      shf_adj = shf_q;
      if (shf_q[19:16] >= 4'd5) shf_adj[19:16] = shf_q[19:16] + 4'd3;
      if (shf_q[15:12] >= 4'd5) shf_adj[15:12] = shf_q[15:12] + 4'd3;
      if (shf_q[11:8]  >= 4'd5) shf_adj[11:8]  = shf_q[11:8]  + 4'd3;

      case (state_q)
         IDLE: begin
            if (upd_i) begin
               shf_d   = {12'b0, count_i};
               iter_d  = 3'd0;
               state_d = CONV;
            end
         end
         CONV: begin
            shf_d  = {shf_adj[18:0], 1'b0};
            iter_d = iter_q + 3'd1;
            if (iter_q == 3'd7) state_d = LATCH;
            if (upd_i) begin
               pend_d     = 1'b1;
               pend_val_d = count_i;
            end
         end
         LATCH: begin
            digits_d = shf_q[19:8];
            done_d   = 1'b1;
            // A request arriving this very cycle is newer than the queued one.
            if (pend_q || upd_i) begin
               shf_d   = {12'b0, (upd_i ? count_i : pend_val_q)};
               iter_d  = 3'd0;
               pend_d  = 1'b0;
               state_d = CONV;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wrap    = (presc_q == PW'(SCAN_DIV - 1));
      presc_d = wrap ? '0 : presc_q + 1'b1;
      idx_d   = idx_q;
      if (wrap) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;

      nib   = digits_q[3:0];
      blank = 1'b0;
      dig_d = 3'b001;
      case (idx_q)
         2'd1: begin
            nib   = digits_q[7:4];
            blank = BLANK_LZ && (digits_q[11:8] == 4'd0) && (digits_q[7:4] == 4'd0);
            dig_d = 3'b010;
         end
         2'd2: begin
            nib   = digits_q[11:8];
            blank = BLANK_LZ && (digits_q[11:8] == 4'd0);
            dig_d = 3'b100;
         end
         default: begin
            nib   = digits_q[3:0];
            blank = 1'b0;
            dig_d = 3'b001;
         end
      endcase
      seg_d = blank ? 8'h00 : {1'b0, dec7(nib)};
   end

   always_ff @(posedge clk_i or posedge rst_int) begin
      if (rst_int) begin
         state_q    <= IDLE;
         shf_q      <= '0;
         iter_q     <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         digits_q   <= '0;
         done_q     <= 1'b0;
         presc_q    <= '0;
         idx_q      <= '0;
         seg_q      <= '0;
         dig_q      <= '0;
      end else begin
         state_q    <= state_d;
         shf_q      <= shf_d;
         iter_q     <= iter_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         digits_q   <= digits_d;
         done_q     <= done_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         dig_q      <= dig_d;
      end
   end

   assign busy_o = (state_q != IDLE);
   assign done_o = done_q;
   assign seg_o  = seg_q;
   assign dig_o  = dig_q;

endmodule

// File: tb/tb_segment_scan_ctrl.sv
// Scoreboard bench for segment_scan_ctrl: blanking and non-blanking instances
// share stimulus; expected display values are queued at request time.
module tb_segment_scan_ctrl;

   logic       clk, rst, upd;
   logic [7:0] cnt;
   logic       busy_a, done_a, busy_b, done_b;
   logic [7:0] seg_a, seg_b;
   logic [2:0] dig_a, dig_b;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q[$];

   logic       busy_s[0:18];
   logic       done_s[0:18];
   logic [2:0] dig_s[0:18];
   logic [7:0] sega_s[0:18];
   logic [7:0] segb_s[0:18];

   segment_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (
      .clk_i(clk), .rst_i(rst), .upd_i(upd), .count_i(cnt),
      .busy_o(busy_a), .done_o(done_a), .seg_o(seg_a), .dig_o(dig_a));

   segment_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_b (
      .clk_i(clk), .rst_i(rst), .upd_i(upd), .count_i(cnt),
      .busy_o(busy_b), .done_o(done_b), .seg_o(seg_b), .dig_o(dig_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] seg_of(input int d);
      case (d)
         0: return 8'h3f;  1: return 8'h06;  2: return 8'h5b;  3: return 8'h4f;
         4: return 8'h66;  5: return 8'h6d;  6: return 8'h7d;  7: return 8'h07;
         8: return 8'h7f;  9: return 8'h6f;
         default: return 8'hff;
      endcase
   endfunction

   function automatic logic [7:0] exp_seg(input int val, input int pos, input bit blank);
      int h, t, o;
      h = val / 100;
      t = (val / 10) % 10;
      o = val % 10;
      if (pos == 0) return seg_of(o);
      if (pos == 1) return (blank && h == 0 && t == 0) ? 8'h00 : seg_of(t);
      return (blank && h == 0) ? 8'h00 : seg_of(h);
   endfunction

   function automatic int idx_of(input logic [2:0] d);
      case (d)
         3'b001:  return 0;
         3'b010:  return 1;
         3'b100:  return 2;
         default: return 3;
      endcase
   endfunction

   task automatic check_sample(input int val, input logic [2:0] da, input logic [7:0] sa,
                               input logic [2:0] db, input logic [7:0] sb);
      int ia, ib;
      ia = idx_of(da);
      ib = idx_of(db);
      chk("dig_onehot_a", da, (ia < 3) ? da : 3'b001);
      chk("dig_onehot_b", db, (ib < 3) ? db : 3'b001);
      if (ia < 3) chk($sformatf("seg_a_v%0d_p%0d", val, ia), sa, exp_seg(val, ia, 1'b1));
      if (ib < 3) chk($sformatf("seg_b_v%0d_p%0d", val, ib), sb, exp_seg(val, ib, 1'b0));
   endtask

   task automatic check_slots(input int val, input int ncyc);
      repeat (ncyc) begin
         @(negedge clk);
         check_sample(val, dig_a, seg_a, dig_b, seg_b);
      end
   endtask

   task automatic pop_exp(output int v);
      if (exp_q.size() == 0) begin
         chk("sb_underflow", 1, 0);
         v = 0;
      end else begin
         v = exp_q.pop_front();
      end
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_a) begin
            ok = 1'b1;
            break;
         end
      end
      chk("done_within_budget", ok, 1'b1);
   endtask

   task automatic run_one(input int val);
      bit ok;
      int v;
      @(negedge clk);
      upd = 1'b1;
      cnt = 8'(val);
      exp_q.push_back(val);
      @(negedge clk);
      upd = 1'b0;
      wait_done(20, ok);
      chk("done_b_match", done_b, done_a);
      pop_exp(v);
      check_slots(v, 14);
   endtask

   initial begin
      int v, j, busy_bad, done_cnt;
      bit ok;

      rst = 1'b1;
      upd = 1'b0;
      cnt = 8'd0;

      repeat (5) @(negedge clk);
      chk("rst_seg", seg_a, 8'h00);
      chk("rst_dig", dig_a, 3'b000);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
      rst = 1'b0;

      // First active slot after release must be ones, each slot 4 cycles.
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (dig_a != 3'b000) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("scan_start", ok, 1'b1);
      for (int k = 0; k < 16; k++) begin
         j = (k / 4) % 3;
         chk($sformatf("scan_dig_%0d", k), dig_a, 3'b001 << j);
         chk($sformatf("scan_seg_%0d", k), seg_a, (j == 0) ? 8'h3f : 8'h00);
         @(negedge clk);
      end

      // Latency / handshake with 255.
      upd = 1'b1;
      cnt = 8'd255;
      exp_q.push_back(255);
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         if (k == 0) upd = 1'b0;
         chk($sformatf("lat_busy_%0d", k), busy_a, (k < 9));
         chk($sformatf("lat_done_%0d", k), done_a, (k == 9));
      end
      pop_exp(v);
      check_slots(v, 14);

      run_one(7);
      run_one(105);
      run_one(100);
      run_one(0);

      // Queued requests: 42 then 99 and 13 during conversion; 13 wins.
      @(negedge clk);
      upd = 1'b1;
      cnt = 8'd42;
      exp_q.push_back(42);
      exp_q.push_back(13);
      for (int k = 0; k <= 18; k++) begin
         @(negedge clk);
         busy_s[k] = busy_a;
         done_s[k] = done_a;
         dig_s[k]  = dig_a;
         sega_s[k] = seg_a;
         segb_s[k] = seg_b;
         if (k == 0) upd = 1'b0;
         if (k == 2) begin upd = 1'b1; cnt = 8'd99; end
         if (k == 3) upd = 1'b0;
         if (k == 4) begin upd = 1'b1; cnt = 8'd13; end
         if (k == 5) upd = 1'b0;
      end
      busy_bad = 0;
      for (int k = 0; k < 18; k++) if (busy_s[k] !== 1'b1) busy_bad++;
      chk("pend_busy_gaps", busy_bad, 0);
      chk("pend_busy_end", busy_s[18], 1'b0);
      for (int k = 0; k <= 18; k++)
         chk($sformatf("pend_done_%0d", k), done_s[k], (k == 9 || k == 18));
      pop_exp(v);
      for (int k = 10; k <= 17; k++)
         check_sample(v, dig_s[k], sega_s[k], dig_s[k], segb_s[k]);
      pop_exp(v);
      check_slots(v, 14);

      // Asynchronous reset mid-conversion after 88 is on display.
      run_one(88);
      @(negedge clk);
      upd = 1'b1;
      cnt = 8'd50;
      @(negedge clk);
      upd = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", busy_a, 1'b0);
      chk("arst_done", done_a, 1'b0);
      chk("arst_seg", seg_a, 8'h00);
      chk("arst_dig", dig_a, 3'b000);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      busy_bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done_a) done_cnt++;
         if (busy_a) busy_bad++;
      end
      chk("arst_no_done", done_cnt, 0);
      chk("arst_no_busy", busy_bad, 0);
      check_slots(0, 14);
      chk("sb_leftover", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/segment_scan_ctrl.md
Name: segment_scan_ctrl

Overview:
- Sequencer for the board's multiplexed 3-digit 7-segment display.
- Accepts an 8-bit count through a request handshake and converts it to BCD with a sequential double-dabble engine (one bit per cycle).
- Holds the converted digits and time-multiplexes them onto one shared segment bus with a one-hot digit-enable scan.
- Sits between the LED-count logic and the segment pins; replaces static per-digit decoding.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays enabled per scan slot; legal range 2..2^20.
- BLANK_LZ, 1, 1 = blank leading zeros on hundreds/tens; 0 = always show all three digits.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous, active-high reset.
- upd_i  input  1  update request; sampled on rising edge of clk_i.
- count_i  input  8  value to display, sampled together with upd_i.
- busy_o  output  1  conversion in progress.
- done_o  output  1  one-cycle pulse; new digits are now displayed.
- seg_o  output  8  [6:0] = segments g..a, active-high; [7] = decimal point, always 0.
- dig_o  output  3  one-hot digit enable, active-high; bit0 = ones, bit1 = tens, bit2 = hundreds.

Behaviour:
- Reset values:
  - busy_o=0, done_o=0, seg_o=8'h00, dig_o=3'b000.
  - Stored digits = 0,0,0; pending flag cleared; scan index 0; prescaler 0.
- Clock and reset:
  - One clock domain, clk_i only.
  - rst_i is applied asynchronously and released synchronously (2-flop release in this block).
- FSM states IDLE, CONV, LATCH:
  - IDLE: on upd_i=1, load shifter {12'b0, count_i}, clear iteration counter, go to CONV.
  - CONV: 8 cycles. Each cycle, add 3 to every BCD nibble >=5, then shift the 20-bit shifter left by 1. After the 8th cycle go to LATCH.
  - LATCH: copy the BCD nibbles to the display digit registers and pulse done_o.
    - If pending is set: reload the shifter from the pending value, clear pending, go directly to CONV (no IDLE cycle).
    - Otherwise go to IDLE.
- Latency and handshake:
  - upd_i sampled at edge N gives busy_o=1 from edge N to edge N+9.
  - Display digits update and done_o=1 at edge N+9; busy_o=0 at N+9 unless a pending request restarts conversion.
- Pending request:
  - upd_i=1 while in CONV or LATCH sets pending and captures count_i; the latest capture wins.
  - Only one request is queued; intermediate values are dropped.
  - upd_i in LATCH is captured and serviced from the pending path, not lost.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - On wrap, the scan index advances 0→1→2→0.
  - seg_o and dig_o are registered: they reflect the scan index and digit registers with 1-cycle latency.
  - First output after reset release: dig_o=001.
- Decode (value→seg[6:0]): 0:3f 1:06 2:5b 3:4f 4:66 5:6d 6:7d 7:07 8:7f 9:6f.
- Blanking (BLANK_LZ=1):
  - Hundreds is blanked when it is 0.
  - Tens is blanked when hundreds and tens are both 0.
  - Ones is never blanked.
  - A blanked slot drives seg_o=8'h00 while dig_o stays one-hot, so scan timing is uniform.
- Digit registers change only at LATCH. A scan slot in progress switches to the new value mid-slot with no glitch beyond the 1-cycle output register.
- Reset mid-operation: conversion aborted, no done_o, pending dropped, display returns to "0".

Test Plan:
- Hold rst_i 5 cycles → seg_o=00, dig_o=000 during reset. After release with SCAN_DIV=4: dig_o=001, seg_o=3f; then 010 and 100 slots with seg_o=00 (blanked).
- SCAN_DIV=4, idle → dig_o sequence 001,010,100,001, each held exactly 4 cycles.
- upd_i=1, count_i=255 at edge N → busy_o high N..N+9, done_o high only at N+9. Scan shows ones=6d, tens=6d, hundreds=5b.
- count 7 → hundreds/tens seg_o=00, ones=07. count 105 → hundreds=06, tens=3f (not blanked), ones=6d. BLANK_LZ=0, count 7 → hundreds=tens=3f.
- upd 42 at N, upd 99 at N+3, upd 13 at N+5 → done_o at N+9 (display 42) and N+18 (display 13). busy_o never drops between; 99 never displayed.
- Assert rst_i asynchronously at N+4 mid-conversion (after prior value 88 displayed) → busy_o=0 immediately, no done_o, display returns to ones=3f with others blank.
